instr_encoder: RTL and testbench

Instruction encoder and loader for the MIPS core's instruction memory, the write side feeding the opcode/funct decoder. It accepts symbolic instruction requests (mnemonic code plus register, shift, immediate and target fields) over a valid/ready handshake. It packs each request into a 32-bit MIPS word and writes it to instruction memory at consecutive word addresses from a base. Boot/test logic uses it to load programs without a pre-built memory image.

---
 rtl/instr_encoder.sv | 158 +++++++++++++++
 tb/tb_instr_encoder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs symbolic MIPS instruction requests into 32-bit words and writes them
// to instruction memory at consecutive word addresses starting from BASE_ADDR.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_mnem,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [4:0] M_SLL = 5'd4;
  localparam logic [4:0] M_SRL = 5'd5;
  localparam logic [4:0] M_LUI = 5'd15;
  localparam logic [4:0] M_J   = 5'd17;
  localparam logic [4:0] M_END = 5'd31;

  // Returns {supported, word}; END and codes 18-30 report unsupported.
  function automatic logic [32:0] encode(
    input logic [4:0]  mnem,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [5:0]  code;
    logic        r_type;
    logic        ok;
    logic [4:0]  rs_eff;
    logic [4:0]  sh_eff;
    logic [31:0] word;
    code   = 6'h00;
    r_type = 1'b0;
    ok     = 1'b1;
    case (mnem)
      5'd0:  begin r_type = 1'b1; code = 6'h20; end
      5'd1:  begin r_type = 1'b1; code = 6'h21; end
      5'd2:  begin r_type = 1'b1; code = 6'h22; end
      5'd3:  begin r_type = 1'b1; code = 6'h23; end
      5'd4:  begin r_type = 1'b1; code = 6'h00; end
      5'd5:  begin r_type = 1'b1; code = 6'h02; end
      5'd6:  begin r_type = 1'b1; code = 6'h2A; end
      5'd7:  begin r_type = 1'b1; code = 6'h24; end
      5'd8:  begin r_type = 1'b1; code = 6'h25; end
      5'd9:  code = 6'h09;
      5'd10: code = 6'h04;
      5'd11: code = 6'h05;
      5'd12: code = 6'h0A;
      5'd13: code = 6'h0D;
      5'd14: code = 6'h23;
      5'd15: code = 6'h0F;
      5'd16: code = 6'h2B;
      5'd17: code = 6'h02;
      default: ok = 1'b0;
    endcase
    // Shifts carry no rs; every other R-type carries no shamt; LUI carries no rs.
    if (r_type) begin
      rs_eff = (mnem == M_SLL || mnem == M_SRL) ? 5'd0 : rs;
      sh_eff = (mnem == M_SLL || mnem == M_SRL) ? shamt : 5'd0;
      word   = {6'h00, rs_eff, rt, rd, sh_eff, code};
    end else if (mnem == M_J) begin
      word = {code, target};
    end else begin
      rs_eff = (mnem == M_LUI) ? 5'd0 : rs;
      word   = {code, rs_eff, rt, imm};
    end
    return {ok, word};
  endfunction

  logic [1:0]      state;
  logic            we_p1;
  logic [32:0]     enc;
  logic [ADDR_W:0] count_next;
  logic            handshake;

  assign enc        = encode(req_mnem, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);
  assign count_next = count + (ADDR_W+1)'(1);
  assign handshake  = req_valid & req_ready;
  // A restart landing in the WRITE cycle cancels the pending strobe.
  assign im_we      = we_p1 & ~start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      we_p1     <= 1'b0;
      im_addr   <= ADDR_W'(BASE_ADDR);
      im_wdata  <= 32'h0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (start) begin
      state     <= S_ACCEPT;
      req_ready <= 1'b1;
      we_p1     <= 1'b0;
      im_addr   <= ADDR_W'(BASE_ADDR);
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (handshake) begin
            if (req_mnem == M_END) begin
              state     <= S_DONE;
              req_ready <= 1'b0;
              done      <= 1'b1;
            end else if (enc[32]) begin
              state     <= S_WRITE;
              req_ready <= 1'b0;
              we_p1     <= 1'b1;
              im_wdata  <= enc[31:0];
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          we_p1   <= 1'b0;
          im_addr <= im_addr + ADDR_W'(1);
          count   <= count_next;
          if (count_next == (ADDR_W+1)'(DEPTH)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_ACCEPT;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, handshake timing, err, DEPTH limit,
// restart during WRITE and asynchronous reset mid-session.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        req_valid = 1'b0;
  logic [4:0]  req_mnem = '0, req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;

  logic        req_ready, im_we, done, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] count;

  logic        req_ready4, im_we4, done4, err4;
  logic [9:0]  im_addr4;
  logic [31:0] im_wdata4;
  logic [10:0] count4;

  int checks = 0;
  int errors = 0;

  logic [4:0]  pm   [4] = '{5'd13, 5'd14, 5'd10, 5'd17};
  logic [4:0]  prs  [4] = '{5'd0, 5'd29, 5'd8, 5'd0};
  logic [4:0]  prt  [4] = '{5'd8, 5'd9, 5'd9, 5'd0};
  logic [15:0] pimm [4] = '{16'h00FF, 16'hFFFC, 16'h0003, 16'h0000};
  logic [25:0] ptg  [4] = '{26'h0, 26'h0, 26'h0, 26'h0000010};
  logic [31:0] pw   [4] = '{32'h340800FF, 32'h8FA9FFFC, 32'h11090003, 32'h08000010};

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count),
    .done(done), .err(err)
  );

  instr_encoder #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .req_valid(req_valid), .req_ready(req_ready4),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4), .count(count4),
    .done(done4), .err(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] tg);
    req_mnem = m; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_imm = imm; req_target = tg;
  endtask

  // Presents one request and returns just after its handshake edge.
  task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tg);
    int n;
    n = 0;
    set_req(m, rs, rt, rd, sh, imm, tg);
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout req_ready=%b required 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({req_ready, im_we, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl ready/we/done/err=%b required 0000", {req_ready, im_we, done, err});
    end
    checks++;
    if (im_addr !== 10'd0 || im_wdata !== 32'h0 || count !== 11'd0) begin
      errors++;
      $display("FAIL reset_data addr=%0d wdata=%h count=%0d required 0/0/0", im_addr, im_wdata, count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready req_ready=%b required 0", req_ready);
    end
  endtask

  task automatic test_single();
    pulse_start();
    checks++;
    if (req_ready !== 1'b1 || count !== 11'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_state ready=%b count=%0d done=%b required 1/0/0", req_ready, count, done);
    end
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++;
    if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h00221821) begin
      errors++;
      $display("FAIL addu_write we=%b addr=%0d wdata=%h required 1/0/00221821", im_we, im_addr, im_wdata);
    end
    tick();
    checks++;
    if (count !== 11'd1 || im_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL addu_after count=%0d we=%b ready=%b required 1/0/1", count, im_we, req_ready);
    end
  endtask

  task automatic test_program();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(pm[i], prs[i], prt[i], 5'd0, 5'd0, pimm[i], ptg[i]);
      checks++;
      if (im_we !== 1'b1 || im_addr !== 10'(i) || im_wdata !== pw[i]) begin
        errors++;
        $display("FAIL prog_word%0d we=%b addr=%0d wdata=%h required 1/%0d/%h",
                 i, im_we, im_addr, im_wdata, i, pw[i]);
      end
      tick();
    end
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    checks++;
    if (done !== 1'b1 || count !== 11'd4 || req_ready !== 1'b0 || im_we !== 1'b0) begin
      errors++;
      $display("FAIL prog_end done=%b count=%0d ready=%b we=%b required 1/4/0/0",
               done, count, req_ready, im_we);
    end
    tick();
    checks++;
    if (done !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL prog_hold done=%b ready=%b required 1/0", done, req_ready);
    end
  endtask

  task automatic test_fields();
    pulse_start();
    send(5'd4, 5'd7, 5'd4, 5'd5, 5'd2, 16'h0, 26'h0);
    checks++;
    if (im_wdata !== 32'h00042880) begin
      errors++;
      $display("FAIL sll_word wdata=%h required 00042880", im_wdata);
    end
    tick();
    send(5'd15, 5'd3, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
    checks++;
    if (im_wdata !== 32'h3C011234 || im_addr !== 10'd1) begin
      errors++;
      $display("FAIL lui_word wdata=%h addr=%0d required 3c011234/1", im_wdata, im_addr);
    end
    tick();
  endtask

  task automatic test_bad_mnem();
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'h0);
    checks++;
    if (im_wdata !== 32'h00221820 || im_addr !== 10'd0) begin
      errors++;
      $display("FAIL add_word wdata=%h addr=%0d required 00221820/0", im_wdata, im_addr);
    end
    tick();
    send(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++;
    if (err !== 1'b1 || im_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_mnem err=%b we=%b ready=%b required 1/0/1", err, im_we, req_ready);
    end
    send(5'd8, 5'd1, 5'd2, 5'd4, 5'd0, 16'h0, 26'h0);
    checks++;
    if (im_we !== 1'b1 || im_addr !== 10'd1 || im_wdata !== 32'h00222025 || err !== 1'b1) begin
      errors++;
      $display("FAIL after_bad we=%b addr=%0d wdata=%h err=%b required 1/1/00222025/1",
               im_we, im_addr, im_wdata, err);
    end
    tick();
    pulse_start();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear err=%b required 0", err);
    end
  endtask

  task automatic test_depth();
    int writes;
    logic chk_done;
    writes = 0;
    chk_done = 1'b0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    set_req(5'd9, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0);
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (chk_done) begin
        chk_done = 1'b0;
        checks++;
        if (done4 !== 1'b1) begin
          errors++;
          $display("FAIL depth_done_timing done=%b required 1", done4);
        end
      end
      if (im_we4) begin
        writes++;
        if (writes == 4) chk_done = 1'b1;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (writes != 4) begin
      errors++;
      $display("FAIL depth_writes writes=%0d required 4", writes);
    end
    checks++;
    if (done4 !== 1'b1 || count4 !== 11'd4 || req_ready4 !== 1'b0 || im_addr4 !== 10'd4) begin
      errors++;
      $display("FAIL depth_state done=%b count=%0d ready=%b addr=%0d required 1/4/0/4",
               done4, count4, req_ready4, im_addr4);
    end
    checks++;
    if (im_wdata4 !== 32'h24010005 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL depth_word wdata=%h err=%b required 24010005/0", im_wdata4, err4);
    end
  endtask

  task automatic test_start_in_write();
    pulse_start();
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    checks++;
    if (im_we !== 1'b1) begin
      errors++;
      $display("FAIL sw_pre_we we=%b required 1", im_we);
    end
    start = 1'b1;
    #1;
    checks++;
    if (im_we !== 1'b0) begin
      errors++;
      $display("FAIL sw_drop we=%b required 0", im_we);
    end
    tick();
    start = 1'b0;
    checks++;
    if (im_we !== 1'b0 || count !== 11'd0 || req_ready !== 1'b1 || im_addr !== 10'd0) begin
      errors++;
      $display("FAIL sw_restart we=%b count=%0d ready=%b addr=%0d required 0/0/1/0",
               im_we, count, req_ready, im_addr);
    end
    send(5'd13, 5'd0, 5'd8, 5'd0, 5'd0, 16'h00FF, 26'h0);
    checks++;
    if (im_we !== 1'b1 || im_addr !== 10'd0 || im_wdata !== 32'h340800FF) begin
      errors++;
      $display("FAIL sw_next we=%b addr=%0d wdata=%h required 1/0/340800ff", im_we, im_addr, im_wdata);
    end
    tick();
    checks++;
    if (count !== 11'd1) begin
      errors++;
      $display("FAIL sw_count count=%0d required 1", count);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, im_we, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ctrl ready/we/done/err=%b required 0000", {req_ready, im_we, done, err});
    end
    checks++;
    if (im_addr !== 10'd0 || im_wdata !== 32'h0 || count !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid_data addr=%0d wdata=%h count=%0d required 0/0/0", im_addr, im_wdata, count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b0 || im_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle ready=%b we=%b required 0/0", req_ready, im_we);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_program();
    test_fields();
    test_bad_mnem();
    test_depth();
    test_start_in_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
